// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller.
//   cmd_e   : command encoding on the cmd port
//   state_e : controller FSM states
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default stack geometry
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_PUSH   = 3'd1,
    CMD_POP    = 3'd2,
    CMD_ADD    = 3'd3,
    CMD_SUB    = 3'd4,
    CMD_SWAP   = 3'd5,
    CMD_DUP    = 3'd6,
    CMD_CLRERR = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/stack_alu.sv
// Combinational add/subtract for the two top stack entries.
//   a      : second entry (left operand)
//   b      : top entry (right operand)
//   sub    : 0 = a+b, 1 = a-b
//   result : result mod 2^WIDTH
//   carry  : carry-out on add, borrow (a<b) on subtract
module stack_alu
  import stack_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] ext;

  // One extra bit: on subtract it wraps to 1 exactly when a < b.
  always_comb begin
    ext    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    result = ext[WIDTH-1:0];
    carry  = ext[WIDTH];
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: accepts one command at a time, executes it against a
// DEPTH x WIDTH register stack, and returns the new top as a response.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/cmd/in_data : command channel
//   push/pop/popmath/popswap      : one-cycle cell control pulses (EXEC only)
//   prevnext                      : swap direction, 1 only during an executed SWAP
//   mathdata                      : ALU result to the top cell during ADD/SUB
//   top/count/full/empty          : live stack status
//   out_valid/out_ready/out_data  : response channel (top after the command)
//   carry, err_ovf, err_unf       : last math carry/borrow, sticky errors
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; latch cmd/in_data on acceptance
// EXEC    | one cycle: pulse, update storage/count/flags
// RESP    | present top on out_data until out_ready
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 cmd,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       push,
  output logic                       pop,
  output logic                       popmath,
  output logic                       popswap,
  output logic                       prevnext,
  output logic [WIDTH-1:0]           mathdata,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       carry,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic [AW-1:0]    wr_idx, top_idx, sec_idx;
  logic             is_full, is_empty, lt2;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // Indices only matter when the guarding count check passes, so the
  // wrap-around at count 0/1 is harmless.
  assign wr_idx   = AW'(count_q);
  assign top_idx  = AW'(count_q - CW'(1));
  assign sec_idx  = AW'(count_q - CW'(2));
  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign lt2      = (count_q < CW'(2));

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (mem_q[sec_idx]),
    .b      (mem_q[top_idx]),
    .sub    (cmd_q == CMD_SUB),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign top      = is_empty ? '0 : mem_q[top_idx];
  assign count    = count_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign out_data = out_valid ? top : '0;
  assign carry    = carry_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    mem_d     = mem_q;
    count_d   = count_q;
    carry_d   = carry_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    popmath   = 1'b0;
    popswap   = 1'b0;
    prevnext  = 1'b0;
    mathdata  = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cmd_d   = cmd_e'(cmd);
          data_d  = in_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_RESP;
        case (cmd_q)
          CMD_PUSH: begin
            if (is_full) err_ovf_d = 1'b1;
            else begin
              push           = 1'b1;
              mem_d[wr_idx]  = data_q;
              count_d        = count_q + CW'(1);
            end
          end
          CMD_DUP: begin
            if (is_empty)     err_unf_d = 1'b1;
            else if (is_full) err_ovf_d = 1'b1;
            else begin
              push           = 1'b1;
              mem_d[wr_idx]  = mem_q[top_idx];
              count_d        = count_q + CW'(1);
            end
          end
          CMD_POP: begin
            if (is_empty) err_unf_d = 1'b1;
            else begin
              pop            = 1'b1;
              mem_d[top_idx] = '0;
              count_d        = count_q - CW'(1);
            end
          end
          CMD_ADD, CMD_SUB: begin
            if (lt2) err_unf_d = 1'b1;
            else begin
              popmath        = 1'b1;
              mathdata       = alu_res;
              mem_d[sec_idx] = alu_res;
              mem_d[top_idx] = '0;
              count_d        = count_q - CW'(1);
              carry_d        = alu_carry;
            end
          end
          CMD_SWAP: begin
            if (lt2) err_unf_d = 1'b1;
            else begin
              popswap        = 1'b1;
              prevnext       = 1'b1;
              mem_d[sec_idx] = mem_q[top_idx];
              mem_d[top_idx] = mem_q[sec_idx];
            end
          end
          CMD_CLRERR: begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
          end
          default: ;
        endcase
      end

      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      data_q    <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      count_q   <= count_d;
      carry_q   <= carry_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] in_data;
  logic             push, pop, popmath, popswap, prevnext;
  logic [WIDTH-1:0] mathdata, top, out_data;
  logic [CW-1:0]    count;
  logic             full, empty, out_valid, out_ready, carry, err_ovf, err_unf;

  always #5 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .in_data(in_data), .push(push), .pop(pop), .popmath(popmath),
    .popswap(popswap), .prevnext(prevnext), .mathdata(mathdata), .top(top),
    .count(count), .full(full), .empty(empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .carry(carry),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  typedef struct {
    int  data;
    int  cnt;
    bit  carry;
    bit  ovf;
    bit  unf;
    int  pulse;   // 0 none, 1 push, 2 pop, 3 popmath, 4 popswap
    int  math;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 held low

  // reference model: a plain queue of integers
  int   stk[$];
  bit   m_carry, m_ovf, m_unf;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s", nm);
  endtask

  function automatic void model_reset();
    stk.delete();
    m_carry = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic exp_t model(input int c, input int d);
    exp_t e;
    int s, t, r;
    e.pulse = 0;
    e.math  = 0;
    case (c)
      1: if (stk.size() == DEPTH) m_ovf = 1;
         else begin stk.push_back(d); e.pulse = 1; end
      6: if (stk.size() == 0) m_unf = 1;
         else if (stk.size() == DEPTH) m_ovf = 1;
         else begin stk.push_back(stk[$]); e.pulse = 1; end
      2: if (stk.size() == 0) m_unf = 1;
         else begin void'(stk.pop_back()); e.pulse = 2; end
      3, 4: if (stk.size() < 2) m_unf = 1;
         else begin
           t = stk.pop_back();
           s = stk.pop_back();
           if (c == 3) begin
             m_carry = (s + t) >= (1 << WIDTH);
             r = (s + t) % (1 << WIDTH);
           end else begin
             m_carry = s < t;
             r = (s - t + (1 << WIDTH)) % (1 << WIDTH);
           end
           stk.push_back(r);
           e.pulse = 3;
           e.math  = r;
         end
      5: if (stk.size() < 2) m_unf = 1;
         else begin
           t = stk[$];
           stk[stk.size()-1] = stk[stk.size()-2];
           stk[stk.size()-2] = t;
           e.pulse = 4;
         end
      7: begin m_ovf = 0; m_unf = 0; end
      default: ;
    endcase
    e.data  = (stk.size() == 0) ? 0 : stk[$];
    e.cnt   = stk.size();
    e.carry = m_carry;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic do_cmd(input int c, input int d);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    cmd      = 3'(c);
    in_data  = WIDTH'(d);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = model(c, d);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: pulses, hold stability, response scoreboard
  initial begin : mon
    bit   hold_prev;
    int   held;
    int   pulse_kind, pulse_n, math_obs, nb;
    exp_t e;
    hold_prev = 0; held = 0; pulse_kind = 0; pulse_n = 0; math_obs = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        hold_prev = 0; pulse_kind = 0; pulse_n = 0;
        continue;
      end
      nb = int'(push) + int'(pop) + int'(popmath) + int'(popswap);
      if (nb != 0) begin
        chk("pulse_onehot", nb, 1);
        pulse_kind = push ? 1 : pop ? 2 : popmath ? 3 : 4;
        pulse_n++;
        if (popmath) math_obs = int'(mathdata);
      end
      if (prevnext || popswap) chk("prevnext", int'(prevnext), int'(popswap));
      if (hold_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), held);
        chk("hold_in_ready", int'(in_ready), 0);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) fail_now("unexpected_response");
          else begin
            e = sb.pop_front();
            chk("resp_data",   int'(out_data), e.data);
            chk("resp_count",  int'(count), e.cnt);
            chk("resp_empty",  int'(empty), int'(e.cnt == 0));
            chk("resp_full",   int'(full), int'(e.cnt == DEPTH));
            chk("resp_carry",  int'(carry), int'(e.carry));
            chk("resp_ovf",    int'(err_ovf), int'(e.ovf));
            chk("resp_unf",    int'(err_unf), int'(e.unf));
            chk("resp_pulse",  pulse_kind, e.pulse);
            chk("resp_npulse", pulse_n, int'(e.pulse != 0));
            if (e.pulse == 3) chk("resp_math", math_obs, e.math);
          end
          pulse_kind = 0;
          pulse_n    = 0;
          hold_prev  = 0;
        end else begin
          hold_prev = 1;
          held      = int'(out_data);
        end
      end else hold_prev = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    in_valid = 1'b0; cmd = '0; in_data = '0; rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pulses", int'({push, pop, popmath, popswap, prevnext}), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_errs", int'({err_ovf, err_unf}), 0);
    chk("rst_mathdata", int'(mathdata), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_top", int'(top), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // arithmetic
    do_cmd(1, 3); do_cmd(1, 5); do_cmd(3, 0); do_cmd(2, 0);
    do_cmd(1, 9); do_cmd(1, 12); do_cmd(3, 0); do_cmd(2, 0);
    do_cmd(1, 2); do_cmd(1, 7); do_cmd(4, 0); do_cmd(2, 0);
    drain();

    // overflow
    for (int i = 0; i < DEPTH; i++) do_cmd(1, i + 1);
    do_cmd(1, 4);
    do_cmd(6, 0);
    drain();
    chk("ovf_full", int'(full), 1);
    chk("ovf_top", int'(top), DEPTH);
    do_cmd(7, 0);
    for (int i = 0; i < DEPTH; i++) do_cmd(2, 0);

    // underflow
    do_cmd(2, 0);
    do_cmd(1, 6); do_cmd(5, 0); do_cmd(3, 0);
    do_cmd(7, 0); do_cmd(2, 0); do_cmd(6, 0);
    do_cmd(0, 0);
    drain();

    // swap with held response
    do_cmd(1, 1); do_cmd(1, 2);
    drain();
    rdy_mode = 2;
    do_cmd(5, 0);
    repeat (6) @(negedge clk);
    chk("hold5_valid", int'(out_valid), 1);
    chk("hold5_in_ready", int'(in_ready), 0);
    chk("hold5_data", int'(out_data), 1);
    rdy_mode = 0;
    drain();

    // reset during EXEC
    do_cmd(1, 6);
    rst_n = 1'b0;
    #1;
    chk("abort_count", int'(count), 0);
    chk("abort_empty", int'(empty), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_push", int'(push), 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1, 10);
    drain();

    // randomized
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 7));
      do_cmd(c, int'($urandom_range(0, (1 << WIDTH) - 1)));
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, default 8, number of stack entries; WIDTH, default 4, data bits per entry.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command offered.
- in_ready  out  1  command accepted when in_valid & in_ready.
- cmd  in  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 SWAP, 6 DUP, 7 CLRERR.
- in_data  in  WIDTH  PUSH operand.
- push, pop, popmath, popswap  out  1 each  one-cycle stack-cell control pulses.
- prevnext  out  1  swap direction to cells: 0 = take previous, 1 = take next.
- mathdata  out  WIDTH  ALU result to the top cell.
- top  out  WIDTH  current top of stack; 0 when empty.
- count  out  clog2(DEPTH+1)  occupied entries.
- full, empty  out  1 each  count==DEPTH, count==0.
- out_valid  in-order response valid; out_ready  in  1  response taken.
- out_data  out  WIDTH  top after the command.
- carry  out  1  ADD carry-out / SUB borrow of the last math command.
- err_ovf, err_unf  out  1 each  sticky overflow / underflow.

Function
REQ-003 SHALL run an FSM with states IDLE, EXEC, RESP.
REQ-004 IDLE: in_ready=1; on acceptance SHALL latch cmd and in_data and go to EXEC.
REQ-005 EXEC: in_ready=0; SHALL assert exactly one matching control pulse for one cycle, update storage and count at the end of the cycle, then go to RESP.
REQ-006 RESP: out_valid=1 and out_data=top (post-update); SHALL hold both stable until out_ready, then go to IDLE. Minimum accept-to-response latency is 2 cycles.
REQ-007 PUSH SHALL write in_data at index count and increment count; DUP SHALL push a copy of top.
REQ-008 POP SHALL decrement count; the vacated entry SHALL be cleared to 0.
REQ-009 ADD SHALL replace the top two entries with (second+top) mod 2^WIDTH, set carry to the carry-out, and decrement count.
REQ-010 SUB SHALL replace the top two entries with (second-top) mod 2^WIDTH, set carry=1 if second<top, and decrement count.
REQ-011 SWAP SHALL exchange the top two entries; count is unchanged.
REQ-012 PUSH or DUP when full SHALL leave the stack unchanged, assert no control pulse, and set err_ovf.
REQ-013 POP when empty, ADD/SUB/SWAP with count<2, or DUP when empty SHALL leave the stack unchanged, assert no control pulse, and set err_unf.
REQ-014 A rejected command SHALL still produce a RESP with the unchanged top.
REQ-015 NOP SHALL pass through EXEC and RESP with no pulse. CLRERR SHALL clear err_ovf and err_unf in EXEC.
REQ-016 carry SHALL change only on ADD or SUB that executes.
REQ-017 Control pulses SHALL be mutually exclusive. prevnext SHALL be 0 except during a SWAP EXEC cycle, where it is 1.

Reset
REQ-018 While rst_n=0 (asynchronous, no clock needed), the block SHALL:
- be in IDLE;
- clear all storage and count to 0;
- drive empty=1, full=0, in_ready=1 (after release);
- drive out_valid=0, pulses=0, carry=0, err flags=0, mathdata=0, out_data=0.
REQ-019 Reset asserted in EXEC or RESP SHALL abort the command with no partial storage update.

Structure
REQ-020 A shared package SHALL hold:
- the cmd encoding enum;
- the FSM state enum;
- default DEPTH and WIDTH constants.
REQ-021 Add/subtract and carry/borrow SHALL be a sub-module stack_alu (combinational, WIDTH-parameterized); the rest is one module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then PUSH 3, PUSH 5, ADD -> out_data 8, count 1, carry 0, one popmath pulse.
- PUSH 9, PUSH 12, ADD -> out_data 5, carry 1. PUSH 2, PUSH 7, SUB -> out_data 11 (0xB), carry 1.
- Eight PUSHes then PUSH 4 -> full=1, err_ovf=1, top unchanged, no push pulse. CLRERR -> err_ovf=0.
- POP on empty -> err_unf=1, count 0, out_valid still 1. SWAP with count 1 -> err_unf=1.
- PUSH 1, PUSH 2, SWAP -> top 1, prevnext=1 only in EXEC. Hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0.
- rst_n low during EXEC of PUSH -> count 0, empty 1, out_valid 0 immediately.
